// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment scan driver.
package display_pkg;

   // Scan phase: all digits dark (BLANK) or one digit lit (SHOW).
   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   localparam int NUM_DIGITS = 4;

   // Active-high segment patterns, bit 0 = a ... bit 6 = g.
   localparam logic [6:0] GLYPH_OFF   = 7'h00;
   localparam logic [6:0] GLYPH_MINUS = 7'h40;
   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;

   // One-hot common enable for the digit at index sel.
   function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] sel);
      digit_onehot = 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to segment glyph translation; 10-15 render as a minus sign.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] glyph
);

   // Glyph lookup; non-decimal codes fall through to the minus sign.
   always_comb begin
      glyph = GLYPH_MINUS;
      case (bcd)
         4'd0:    glyph = GLYPH_0;
         4'd1:    glyph = GLYPH_1;
         4'd2:    glyph = GLYPH_2;
         4'd3:    glyph = GLYPH_3;
         4'd4:    glyph = GLYPH_4;
         4'd5:    glyph = GLYPH_5;
         4'd6:    glyph = GLYPH_6;
         4'd7:    glyph = GLYPH_7;
         4'd8:    glyph = GLYPH_8;
         4'd9:    glyph = GLYPH_9;
         default: glyph = GLYPH_MINUS;
      endcase
   end

endmodule

// File: rtl/display_scan_driver_checker.sv
// Runtime invariants of the scan driver outputs, kept apart from the datapath.
module display_scan_driver_checker (
   input logic       clk,
   input logic       rst_n,
   input logic [6:0] seg,
   input logic       dp,
   input logic [3:0] digit_en,
   input logic       frame_done
);

   // Never more than one digit common driven at a time.
   a_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(digit_en));

   // With no digit enabled the segment and dp lines are dark as well.
   a_dark_blank: assert property (@(posedge clk) disable iff (!rst_n)
      (digit_en == 4'b0000) |-> ((seg == 7'h00) && (dp == 1'b0)));

   // Frame strobe is a single-cycle pulse.
   a_fd_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      frame_done |=> !frame_done);

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-cathode 7-segment display.
// Each digit gets a dark BLANK interval followed by a lit SHOW interval; new
// display values are staged in a pending register and only swapped in at the
// frame boundary so a frame never mixes old and new digits.
module display_scan_driver
   import display_pkg::*;
#(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        lz_suppress,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  digit_en,
   output logic [1:0]  digit_sel,
   output logic        frame_done
);

   // Phase counter is wide enough for the longer of the two phases.
   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_e      state_r;
   scan_state_e      state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic [1:0]       sel_r;
   logic [1:0]       sel_next_s;
   logic             frame_end_s;
   logic             frame_done_r;

   logic             xfer_s;
   logic             pend_valid_r;
   logic [15:0]      pend_digits_r;
   logic [3:0]       pend_dp_r;
   logic             pend_lz_r;

   logic [15:0]      disp_digits_r;
   logic [3:0]       disp_dp_r;
   logic             disp_lz_r;

   logic [3:0]       nibble_s;
   logic             lz_blank_s;
   logic [6:0]       glyph_s;

   // Scan state, phase counter and digit index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_BLANK;
         cnt_r        <= CNT_ZERO;
         sel_r        <= 2'd0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         cnt_r        <= cnt_next_s;
         sel_r        <= sel_next_s;
         frame_done_r <= frame_end_s;
      end
   end

   // Phase sequencing: BLANK(dk) -> SHOW(dk) -> BLANK(dk+1); frame ends leaving SHOW(d3).
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r + CNT_ONE;
      sel_next_s   = sel_r;
      frame_end_s  = 1'b0;
      case (state_r)
         ST_BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               state_next_s = ST_SHOW;
               cnt_next_s   = CNT_ZERO;
            end else begin
               state_next_s = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_r == SHOW_LAST) begin
               state_next_s = ST_BLANK;
               cnt_next_s   = CNT_ZERO;
               sel_next_s   = sel_r + 2'd1;
               frame_end_s  = (sel_r == 2'd3);
            end else begin
               state_next_s = ST_SHOW;
            end
         end
         default: begin
            state_next_s = ST_BLANK;
            cnt_next_s   = CNT_ZERO;
            sel_next_s   = 2'd0;
         end
      endcase
   end

   // A transfer is only possible while the pending slot is empty.
   assign xfer_s     = load_valid & ~pend_valid_r;
   assign load_ready = ~pend_valid_r;

   // Pending slot: filled by the handshake, drained at the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_r  <= 1'b0;
         pend_digits_r <= 16'h0000;
         pend_dp_r     <= 4'b0000;
         pend_lz_r     <= 1'b0;
      end else begin
         if (xfer_s) begin
            pend_valid_r  <= 1'b1;
            pend_digits_r <= digits_in;
            pend_dp_r     <= dp_in;
            pend_lz_r     <= lz_suppress;
         end else if (frame_end_s) begin
            pend_valid_r  <= 1'b0;
         end else begin
            pend_valid_r  <= pend_valid_r;
         end
      end
   end

   // Display registers only change at the frame boundary, and only with a staged value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_digits_r <= 16'h0000;
         disp_dp_r     <= 4'b0000;
         disp_lz_r     <= 1'b0;
      end else if (frame_end_s && pend_valid_r) begin
         disp_digits_r <= pend_digits_r;
         disp_dp_r     <= pend_dp_r;
         disp_lz_r     <= pend_lz_r;
      end else begin
         disp_digits_r <= disp_digits_r;
         disp_dp_r     <= disp_dp_r;
         disp_lz_r     <= disp_lz_r;
      end
   end

   // Select the current nibble and decide whether it is a suppressed leading zero.
   always_comb begin
      nibble_s   = disp_digits_r[3:0];
      lz_blank_s = 1'b0;
      case (sel_r)
         2'd0: begin
            nibble_s   = disp_digits_r[3:0];
            lz_blank_s = 1'b0;
         end
         2'd1: begin
            nibble_s   = disp_digits_r[7:4];
            lz_blank_s = disp_lz_r & (disp_digits_r[15:4] == 12'h000);
         end
         2'd2: begin
            nibble_s   = disp_digits_r[11:8];
            lz_blank_s = disp_lz_r & (disp_digits_r[15:8] == 8'h00);
         end
         2'd3: begin
            nibble_s   = disp_digits_r[15:12];
            lz_blank_s = disp_lz_r & (disp_digits_r[15:12] == 4'h0);
         end
         default: begin
            nibble_s   = 4'h0;
            lz_blank_s = 1'b0;
         end
      endcase
   end

   bcd_to_7seg u_bcd_to_7seg (
      .bcd   (nibble_s),
      .glyph (glyph_s)
   );

   // Output decode from registered state only; BLANK keeps everything dark.
   always_comb begin
      seg      = GLYPH_OFF;
      dp       = 1'b0;
      digit_en = 4'b0000;
      if (state_r == ST_SHOW) begin
         digit_en = digit_onehot(sel_r);
         seg      = lz_blank_s ? GLYPH_OFF : glyph_s;
         dp       = disp_dp_r[sel_r];
      end else begin
         seg      = GLYPH_OFF;
         dp       = 1'b0;
         digit_en = 4'b0000;
      end
   end

   assign digit_sel  = sel_r;
   assign frame_done = frame_done_r;

   display_scan_driver_checker u_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg        (seg),
      .dp         (dp),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver against a frame-position reference model.
module tb_display_scan_driver;

   localparam int PRESCALE     = 4;
   localparam int BLANK_CYCLES = 2;
   localparam int PER_DIGIT    = PRESCALE + BLANK_CYCLES;
   localparam int FRAME        = 4 * PER_DIGIT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  dp_in = 4'b0000;
   logic        lz_suppress = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  digit_en;
   logic [1:0]  digit_sel;
   logic        frame_done;

   display_scan_driver #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .lz_suppress (lz_suppress),
      .seg         (seg),
      .dp          (dp),
      .digit_en    (digit_en),
      .digit_sel   (digit_sel),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: position in the frame since reset release, shown and staged values.
   int          m_pos;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_disp_dp, m_pend_dp;
   logic        m_disp_lz, m_pend_lz, m_pend_v, m_fd;

   // Upstream source: holds an offered value until it is taken.
   logic        src_act;
   logic [15:0] src_d;
   logic [3:0]  src_dp;
   logic        src_lz;
   bit          rand_src;

   logic [6:0]  glyph_tab [0:15];
   logic [15:0] lz_mask [0:4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t (pos %0d)", tag, obs, exp, $time, m_pos);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int digit);
      int v;
      v = int'(m_disp) >> (4 * digit);
      if (m_disp_lz && digit > 0 && v == 0) return 7'h00;
      return glyph_tab[v & 15];
   endfunction

   task automatic model_reset();
      m_pos     = 0;
      m_disp    = 16'h0000;
      m_disp_dp = 4'b0000;
      m_disp_lz = 1'b0;
      m_pend    = 16'h0000;
      m_pend_dp = 4'b0000;
      m_pend_lz = 1'b0;
      m_pend_v  = 1'b0;
      m_fd      = 1'b0;
      src_act   = 1'b0;
   endtask

   task automatic model_step();
      bit xfer;
      bit fend;
      xfer = src_act && !m_pend_v;
      fend = (m_pos % FRAME) == (FRAME - 1);
      m_fd = fend;
      if (fend && m_pend_v) begin
         m_disp    = m_pend;
         m_disp_dp = m_pend_dp;
         m_disp_lz = m_pend_lz;
         m_pend_v  = 1'b0;
      end
      if (xfer) begin
         m_pend    = src_d;
         m_pend_dp = src_dp;
         m_pend_lz = src_lz;
         m_pend_v  = 1'b1;
         src_act   = 1'b0;
      end
      m_pos++;
   endtask

   task automatic check_outputs();
      int p, d;
      bit show;
      logic [31:0] e_en, e_seg, e_dp;
      if (!rst_n) begin
         check("rst_seg", 32'(seg), 32'd0);
         check("rst_dp", 32'(dp), 32'd0);
         check("rst_digit_en", 32'(digit_en), 32'd0);
         check("rst_digit_sel", 32'(digit_sel), 32'd0);
         check("rst_frame_done", 32'(frame_done), 32'd0);
         check("rst_load_ready", 32'(load_ready), 32'd1);
      end else begin
         p    = m_pos % FRAME;
         d    = p / PER_DIGIT;
         show = (p % PER_DIGIT) >= BLANK_CYCLES;
         e_en  = show ? 32'(1 << d) : 32'd0;
         e_seg = show ? 32'(exp_seg(d)) : 32'd0;
         e_dp  = show ? 32'(m_disp_dp[d]) : 32'd0;
         check("digit_sel", 32'(digit_sel), 32'(d));
         check("digit_en", 32'(digit_en), e_en);
         check("seg", 32'(seg), e_seg);
         check("dp", 32'(dp), e_dp);
         check("frame_done", 32'(frame_done), 32'(m_fd));
         check("load_ready", 32'(load_ready), 32'(!m_pend_v));
      end
   endtask

   task automatic offer(input logic [15:0] d, input logic [3:0] dpv, input logic lz);
      src_act = 1'b1;
      src_d   = d;
      src_dp  = dpv;
      src_lz  = lz;
   endtask

   task automatic cycle();
      logic [31:0] r;
      @(negedge clk);
      check_outputs();
      r = $urandom;
      if (rand_src && !src_act && r[31:29] == 3'd0) begin
         offer(r[15:0] & lz_mask[$urandom_range(0, 4)], r[19:16], r[20]);
      end
      r = $urandom;
      load_valid = src_act;
      if (src_act) begin
         digits_in   = src_d;
         dp_in       = src_dp;
         lz_suppress = src_lz;
      end else begin
         digits_in   = r[15:0];
         dp_in       = r[19:16];
         lz_suppress = r[20];
      end
      @(posedge clk);
      if (rst_n) model_step();
   endtask

   task automatic wait_accept(input string tag);
      int n;
      n = 0;
      while (src_act && n < 4 * FRAME) begin
         cycle();
         n++;
      end
      check(tag, 32'(src_act), 32'd0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) glyph_tab[i] = 7'h40;
      glyph_tab[0] = 7'h3F; glyph_tab[1] = 7'h06; glyph_tab[2] = 7'h5B;
      glyph_tab[3] = 7'h4F; glyph_tab[4] = 7'h66; glyph_tab[5] = 7'h6D;
      glyph_tab[6] = 7'h7D; glyph_tab[7] = 7'h07; glyph_tab[8] = 7'h7F;
      glyph_tab[9] = 7'h6F;
      lz_mask[0] = 16'hFFFF; lz_mask[1] = 16'h0FFF; lz_mask[2] = 16'h00FF;
      lz_mask[3] = 16'h000F; lz_mask[4] = 16'h0000;
      rand_src = 1'b0;
      src_d = 16'h0000; src_dp = 4'b0000; src_lz = 1'b0;
      model_reset();

      // Reset held, then first frame of zeros.
      rst_n = 1'b0;
      repeat (3) cycle();
      #2 rst_n = 1'b1;
      repeat (8) cycle();

      // Mid-frame load, with a second value offered while the first is pending.
      offer(16'h1234, 4'b0000, 1'b0);
      wait_accept("accept_1234");
      offer(16'h9999, 4'b0000, 1'b0);
      wait_accept("accept_9999");
      repeat (2 * FRAME) cycle();

      // Leading-zero suppression and minus glyph with a decimal point.
      offer(16'h0007, 4'b0000, 1'b1);
      wait_accept("accept_0007");
      repeat (2 * FRAME) cycle();
      offer(16'h00A0, 4'b0010, 1'b0);
      wait_accept("accept_00A0");
      repeat (2 * FRAME) cycle();

      // Transfer coinciding with the frame-end edge.
      n = 0;
      while (!((m_pos % FRAME) == FRAME - 1 && !m_pend_v) && n < 4 * FRAME) begin
         cycle();
         n++;
      end
      offer(16'h4321, 4'b1000, 1'b0);
      cycle();
      check("accept_at_frame_end", 32'(src_act), 32'd0);
      repeat (2 * FRAME) cycle();

      // Async reset during SHOW(d2) with a value pending.
      n = 0;
      while (!((m_pos % FRAME) == 1 && !m_pend_v) && n < 4 * FRAME) begin
         cycle();
         n++;
      end
      offer(16'h5555, 4'b1111, 1'b0);
      cycle();
      repeat (13) cycle();
      #1 check("pre_reset_digit_en", 32'(digit_en), 32'h4);
      #1 rst_n = 1'b0;
      #1;
      check("async_seg", 32'(seg), 32'd0);
      check("async_digit_en", 32'(digit_en), 32'd0);
      check("async_dp", 32'(dp), 32'd0);
      check("async_digit_sel", 32'(digit_sel), 32'd0);
      check("async_load_ready", 32'(load_ready), 32'd1);
      model_reset();
      repeat (2) cycle();
      #2 rst_n = 1'b1;
      repeat (2 * FRAME) cycle();

      // Randomized traffic.
      rand_src = 1'b1;
      repeat (1500) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter PRESCALE, default 50000: clock cycles each digit is lit (SHOW phase), legal range >= 2.
REQ-002 Parameter BLANK_CYCLES, default 500: clock cycles all digits are dark before each digit (BLANK phase), legal range >= 1.
REQ-003 clk  input  1  the single clock; every register is clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  upstream offers a new display value.
REQ-006 load_ready  output  1  block can accept a new display value.
REQ-007 digits_in  input  16  four BCD nibbles; digit0 (least significant) is bits 3:0 and digit3 is bits 15:12.
REQ-008 dp_in  input  4  decimal point per digit; bit k belongs to digit k.
REQ-009 lz_suppress  input  1  leading-zero suppression request, captured together with digits_in.
REQ-010 seg  output  7  active-high segments, seg[0]=a through seg[6]=g.
REQ-011 dp  output  1  active-high decimal point of the lit digit.
REQ-012 digit_en  output  4  one-hot active-high digit enable; bit k drives the common of digit k.
REQ-013 digit_sel  output  2  index of the current digit; this is the A/B select consumed by the downstream digit decoder.
REQ-014 frame_done  output  1  one-cycle pulse at the end of every 4-digit frame.

Function
REQ-015 The FSM SHALL have two states, BLANK and SHOW, sequenced as BLANK(d0), SHOW(d0), BLANK(d1), SHOW(d1) ... SHOW(d3), then wrap to BLANK(d0).
REQ-016 BLANK SHALL last exactly BLANK_CYCLES cycles and SHOW exactly PRESCALE cycles; one frame = 4*(PRESCALE+BLANK_CYCLES) cycles.
REQ-017 digit_sel SHALL increment modulo 4 on each SHOW->BLANK transition and stay constant otherwise; 3 SHALL wrap to 0.
REQ-018 In BLANK: digit_en=0000, seg=0, dp=0.
REQ-019 In SHOW: digit_en = one-hot(digit_sel); seg = glyph of the displayed nibble; dp = displayed dp bit.
REQ-020 Outputs SHALL be decoded only from registered state (state, digit_sel, display registers), with no input-to-output combinational path.
REQ-021 Glyphs: 0-9 use the standard patterns (0=7'h3F, 1=7'h06, 4=7'h66, 7=7'h07, 8=7'h7F); nibble values 10-15 SHALL show a minus sign (7'h40).
REQ-022 Leading-zero suppression: when the latched lz_suppress=1, digit k (k=3..1) SHALL show seg=0 if it and every more significant digit are 0; digit_en is still asserted. Digit0 is never suppressed.
REQ-023 Handshake: a transfer occurs on a cycle where load_valid=1 and load_ready=1; digits_in, dp_in and lz_suppress are then written to a pending register, and load_ready drops to 0 on the next cycle.
REQ-024 The pending value SHALL move into the display registers on the SHOW(d3)->BLANK(d0) edge. load_ready returns to 1 on that edge, so no frame ever mixes old and new digits.
REQ-025 frame_done SHALL be registered and high for exactly the one cycle after the SHOW(d3)->BLANK(d0) edge.
REQ-026 A transfer in the same cycle as the frame-end edge SHALL still be accepted into pending and shown from the following frame.
REQ-027 load_valid while load_ready=0 SHALL be ignored; upstream holds its value until it is accepted.

Reset
REQ-028 While rst_n=0: state=BLANK, digit_sel=0, phase counter=0, display and pending registers=0, pending flag=0.
REQ-029 While rst_n=0: seg=0, dp=0, digit_en=0000, frame_done=0, load_ready=1.
REQ-030 Assertion mid-frame SHALL darken all outputs immediately and discard any pending value.
REQ-031 After release, operation SHALL begin with a full BLANK(d0) phase.

Structure
REQ-032 A shared package display_pkg SHALL hold: the state enumeration, NUM_DIGITS=4, and the glyph constants, including GLYPH_MINUS=7'h40 and GLYPH_OFF=7'h00.
REQ-033 BCD-to-segment translation SHALL be a combinational sub-module named bcd_to_7seg, instantiated once on the muxed nibble.

Verification (PRESCALE=4, BLANK_CYCLES=2)
REQ-034 Reset check: hold rst_n=0 -> seg=0, digit_en=0, load_ready=1. Release -> 2 dark cycles, then digit_en=0001 with seg=7'h3F for 4 cycles, then 2 dark cycles, then digit_en=0010.
REQ-035 Load 16'h1234, lz=0 mid-frame -> load_ready=0 the next cycle and the display is unchanged. At frame_done, load_ready=1, and the next frame shows d0 seg=7'h66 and d3 seg=7'h06.
REQ-036 Load 16'h0007 with lz=1 -> d3..d1 show seg=0 with their digit_en asserted; d0 shows seg=7'h07.
REQ-037 Load 16'h00A0 with dp_in=4'b0010 -> d1 shows seg=7'h40 with dp=1; all other digits have dp=0.
REQ-038 Second load_valid (16'h9999) while pending -> it is ignored until load_ready=1, accepted on that cycle, and shown one frame after 16'h1234.
REQ-039 rst_n pulsed low during SHOW(d2) -> outputs go dark asynchronously, and the pending value never appears; digit_sel restarts at 0.
